// File: rtl/maluma_issuer_if.sv
// Request / ALU / response bundle for the maluma_issuer sequencer.
// slave: the issuer itself. master: the environment (request source, ALU, response sink).
interface maluma_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        req_mode;
  logic        req_round;
  logic [3:0]  req_tag;

  logic        alu_rst;
  logic        alu_start;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [2:0]  alu_op_code;
  logic        alu_mode_fp;
  logic        alu_round_mode;
  logic [31:0] alu_result;
  logic        alu_valid_out;
  logic [4:0]  alu_flags;

  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic [3:0]  rsp_tag;
  logic        rsp_timeout;
  logic        rsp_ready;

  logic        busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_mode, req_round, req_tag,
    output req_ready,
    output alu_rst, alu_start, alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode,
    input  alu_result, alu_valid_out, alu_flags,
    output rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, req_mode, req_round, req_tag,
    input  req_ready,
    input  alu_rst, alu_start, alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode,
    output alu_result, alu_valid_out, alu_flags,
    input  rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/maluma_issuer.sv
// maluma_issuer: queues FP requests in a small FIFO and sequences them one at a
// time through an external ALU (reset pulse, settle, start pulse, wait with
// timeout), returning one response per request with tag echo.
module maluma_issuer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  maluma_issuer_if.slave  bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [31:0] NAN_SINGLE = 32'h7FC0_0000;
  localparam logic [31:0] NAN_HALF   = 32'h0000_7E00;
  localparam logic [4:0]  FLAGS_NAN  = 5'b01000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_ALU = 3'd1,
    SETTLE  = 3'd2,
    START   = 3'd3,
    WAIT    = 3'd4,
    RESP    = 3'd5
  } state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        mode;
    logic        round;
    logic [3:0]  tag;
  } req_t;

  state_e state_q, state_d;

  req_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_en_q, ready_en_d;

  logic [31:0]   op_a_q, op_a_d;
  logic [31:0]   op_b_q, op_b_d;
  logic [2:0]    op_code_q, op_code_d;
  logic          mode_q, mode_d;
  logic          round_q, round_d;
  logic [3:0]    tag_q, tag_d;

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0]   res_q, res_d;
  logic [4:0]    flags_q, flags_d;
  logic          timeout_q, timeout_d;

  logic          req_ready;
  logic          push;
  logic          pop;
  logic          tmo_hit;
  req_t          head;
  req_t          wr_data;

  assign req_ready = ready_en_q && (count_q < CW'(DEPTH));
  assign push      = bus.req_valid && req_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign head      = mem_q[rd_ptr_q];

  assign wr_data.a     = bus.req_a;
  assign wr_data.b     = bus.req_b;
  assign wr_data.op    = bus.req_op;
  assign wr_data.mode  = bus.req_mode;
  assign wr_data.round = bus.req_round;
  assign wr_data.tag   = bus.req_tag;

  // FIFO storage: written on push only, contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unsupported ops bypass the ALU entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = head.op[2] ? RESP : RST_ALU;
        end
      end
      RST_ALU: state_d = SETTLE;
      SETTLE:  state_d = START;
      START:   state_d = WAIT;
      WAIT: begin
        if (bus.alu_valid_out || tmo_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; alu_rst also follows the external reset
  always_comb begin
    bus.alu_rst   = !rst_n || (state_q == RST_ALU);
    bus.alu_start = (state_q == START);
    bus.rsp_valid = (state_q == RESP);
    bus.busy      = (state_q != IDLE) || (count_q != '0);
    bus.req_ready = req_ready;
  end

  assign bus.alu_op_a       = op_a_q;
  assign bus.alu_op_b       = op_b_q;
  assign bus.alu_op_code    = op_code_q;
  assign bus.alu_mode_fp    = mode_q;
  assign bus.alu_round_mode = round_q;
  assign bus.rsp_result     = res_q;
  assign bus.rsp_flags      = flags_q;
  assign bus.rsp_tag        = tag_q;
  assign bus.rsp_timeout    = timeout_q;

  // FIFO bookkeeping, operand capture, timeout counting and response capture
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ready_en_d = 1'b1;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_code_d  = op_code_q;
    mode_d     = mode_q;
    round_d    = round_q;
    tag_d      = tag_q;
    tmo_cnt_d  = tmo_cnt_q;
    res_d      = res_q;
    flags_d    = flags_q;
    timeout_d  = timeout_q;

    // DEPTH is a power of two, so pointer wrap is the natural overflow
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      op_a_d    = head.mode ? head.a : {16'h0000, head.a[15:0]};
      op_b_d    = head.mode ? head.b : {16'h0000, head.b[15:0]};
      op_code_d = head.op;
      mode_d    = head.mode;
      round_d   = head.round;
      tag_d     = head.tag;
      if (head.op[2]) begin
        res_d     = head.mode ? NAN_SINGLE : NAN_HALF;
        flags_d   = FLAGS_NAN;
        timeout_d = 1'b0;
      end
    end

    if (state_q == START) begin
      tmo_cnt_d = '0;
    end

    // A result arriving on the timeout cycle still wins
    if (state_q == WAIT) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
      if (bus.alu_valid_out) begin
        res_d     = mode_q ? bus.alu_result : {16'h0000, bus.alu_result[15:0]};
        flags_d   = bus.alu_flags;
        timeout_d = 1'b0;
      end else if (tmo_hit) begin
        res_d     = mode_q ? NAN_SINGLE : NAN_HALF;
        flags_d   = FLAGS_NAN;
        timeout_d = 1'b1;
      end
    end
  end

  // Datapath and FIFO control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_code_q  <= '0;
      mode_q     <= 1'b0;
      round_q    <= 1'b0;
      tag_q      <= '0;
      tmo_cnt_q  <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= ready_en_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_code_q  <= op_code_d;
      mode_q     <= mode_d;
      round_q    <= round_d;
      tag_q      <= tag_d;
      tmo_cnt_q  <= tmo_cnt_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_maluma_issuer.sv
// Self-checking bench for maluma_issuer: vector table through a scoreboard plus
// hand sequences for latency, timeout, backpressure and mid-operation reset.
module tb_maluma_issuer;

  localparam int NEVER  = -1;
  localparam int NO_ALU = -2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        mode;
    logic        round;
    logic [3:0]  tag;
    logic [31:0] alu_ret;
    logic [4:0]  alu_fl;
    int          lat;
    logic [31:0] exp_res;
    logic [4:0]  exp_fl;
    logic        exp_tmo;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [3:0]  tag;
    logic        tmo;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        mode;
    logic        round;
    logic [31:0] ret;
    logic [4:0]  fl;
    int          lat;
  } alu_exp_t;

  logic clk;
  logic rst_n;
  logic mdl_v, man_v;
  logic rand_en, rand_rdy, man_rdy;

  int n_checks, n_fail;
  int n_rst_pulse, n_start, n_alu_exp;

  rsp_exp_t rsp_q[$];
  alu_exp_t alu_q[$];
  vec_t     tbl[10];

  maluma_issuer_if bus();

  maluma_issuer #(.DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.alu_valid_out = mdl_v | man_v;
  assign bus.rsp_ready     = rand_en ? rand_rdy : man_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                              input logic mode, input logic round, input logic [3:0] tag,
                              input logic [31:0] ret, input logic [4:0] fl, input int lat,
                              input logic [31:0] eres, input logic [4:0] efl, input logic etmo,
                              input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.mode = mode; v.round = round; v.tag = tag;
    v.alu_ret = ret; v.alu_fl = fl; v.lat = lat;
    v.exp_res = eres; v.exp_fl = efl; v.exp_tmo = etmo; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic expect_vec(input vec_t v);
    rsp_exp_t r;
    alu_exp_t e;
    r.res = v.exp_res; r.fl = v.exp_fl; r.tag = v.tag; r.tmo = v.exp_tmo;
    rsp_q.push_back(r);
    if (v.lat != NO_ALU) begin
      e.a = v.exp_a; e.b = v.exp_b; e.op = v.op; e.mode = v.mode; e.round = v.round;
      e.ret = v.alu_ret; e.fl = v.alu_fl; e.lat = v.lat;
      alu_q.push_back(e);
      n_alu_exp++;
    end
  endtask

  // Called and returns one time unit after a rising edge
  task automatic drive_push(input vec_t v);
    logic ok;
    ok = 1'b0;
    expect_vec(v);
    bus.req_a = v.a; bus.req_b = v.b; bus.req_op = v.op;
    bus.req_mode = v.mode; bus.req_round = v.round; bus.req_tag = v.tag;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("push_accepted", ok, 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && !bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.alu_start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Random response backpressure
  initial begin
    rand_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rand_rdy = ($urandom_range(0, 2) != 0);
    end
  end

  // ALU model: checks operands at the start pulse, answers after lat+1 edges
  initial begin
    alu_exp_t e;
    mdl_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.alu_start) begin
        check("alu_q_nonempty", alu_q.size() != 0, 1'b1);
        if (alu_q.size() != 0) begin
          e = alu_q.pop_front();
          check("alu_op_a", bus.alu_op_a, e.a);
          check("alu_op_b", bus.alu_op_b, e.b);
          check("alu_op_code", bus.alu_op_code, e.op);
          check("alu_mode_fp", bus.alu_mode_fp, e.mode);
          check("alu_round", bus.alu_round_mode, e.round);
          if (e.lat >= 0) begin
            repeat (e.lat + 1) @(posedge clk);
            #1;
            bus.alu_result = e.ret;
            bus.alu_flags  = e.fl;
            mdl_v = 1'b1;
            @(posedge clk);
            #1;
            mdl_v = 1'b0;
          end
        end
      end
    end
  end

  // Response scoreboard, hold-stability and ALU pulse-shape monitor
  initial begin
    rsp_exp_t r;
    logic hold, prev_rst;
    logic [31:0] p_res;
    logic [4:0]  p_fl;
    logic [3:0]  p_tag;
    logic        p_tmo;
    hold = 1'b0;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.alu_rst) begin
        check("alu_rst_width", prev_rst, 1'b0);
        n_rst_pulse++;
      end
      if (rst_n && bus.alu_start) n_start++;
      prev_rst = rst_n && bus.alu_rst;
      if (rst_n && bus.rsp_valid) begin
        if (hold) begin
          check("hold_result", bus.rsp_result, p_res);
          check("hold_flags", bus.rsp_flags, p_fl);
          check("hold_tag", bus.rsp_tag, p_tag);
          check("hold_timeout", bus.rsp_timeout, p_tmo);
        end
        if (bus.rsp_ready) begin
          check("rsp_expected", rsp_q.size() != 0, 1'b1);
          if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            check("rsp_result", bus.rsp_result, r.res);
            check("rsp_flags", bus.rsp_flags, r.fl);
            check("rsp_tag", bus.rsp_tag, r.tag);
            check("rsp_timeout", bus.rsp_timeout, r.tmo);
          end
          hold = 1'b0;
        end else begin
          hold  = 1'b1;
          p_res = bus.rsp_result;
          p_fl  = bus.rsp_flags;
          p_tag = bus.rsp_tag;
          p_tmo = bus.rsp_timeout;
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    vec_t v;
    logic seen;
    int   k, nv;

    n_checks = 0; n_fail = 0; n_rst_pulse = 0; n_start = 0; n_alu_exp = 0;
    rst_n = 1'b0;
    man_v = 1'b0; man_rdy = 1'b1; rand_en = 1'b0;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.req_mode = 1'b0; bus.req_round = 1'b0; bus.req_tag = '0;
    bus.alu_result = '0; bus.alu_flags = '0;

    //        a             b             op    m     r     tag   alu_ret       alu_fl    lat     exp_res       exp_fl    tmo   exp_a         exp_b
    tbl[0] = mk(32'h40000000, 32'h40400000, 3'd0, 1'b1, 1'b0, 4'd3, 32'h40A00000, 5'b00000, 2,      32'h40A00000, 5'b00000, 1'b0, 32'h40000000, 32'h40400000);
    tbl[1] = mk(32'hFFFF4600, 32'h00004000, 3'd3, 1'b0, 1'b0, 4'd5, 32'hABCD4200, 5'b10000, 0,      32'h00004200, 5'b10000, 1'b0, 32'h00004600, 32'h00004000);
    tbl[2] = mk(32'h12345678, 32'h9ABCDEF0, 3'd5, 1'b1, 1'b0, 4'd6, 32'h0,        5'b00000, NO_ALU, 32'h7FC00000, 5'b01000, 1'b0, 32'h0,        32'h0);
    tbl[3] = mk(32'h12345678, 32'h9ABCDEF0, 3'd4, 1'b0, 1'b1, 4'd7, 32'h0,        5'b00000, NO_ALU, 32'h00007E00, 5'b01000, 1'b0, 32'h0,        32'h0);
    tbl[4] = mk(32'h3F800000, 32'h3F800000, 3'd1, 1'b1, 1'b1, 4'd8, 32'h0,        5'b00000, NEVER,  32'h7FC00000, 5'b01000, 1'b1, 32'h3F800000, 32'h3F800000);
    tbl[5] = mk(32'hAAAA3C00, 32'h55553C00, 3'd2, 1'b0, 1'b0, 4'd9, 32'h0,        5'b00000, NEVER,  32'h00007E00, 5'b01000, 1'b1, 32'h00003C00, 32'h00003C00);
    tbl[6] = mk(32'hC0000000, 32'h40000000, 3'd2, 1'b1, 1'b0, 4'd10, 32'hC0800000, 5'b00001, 7,     32'hC0800000, 5'b00001, 1'b0, 32'hC0000000, 32'h40000000);
    tbl[7] = mk(32'h41200000, 32'h3F000000, 3'd3, 1'b1, 1'b1, 4'd11, 32'hDEADBEEF, 5'b11111, 8,     32'h7FC00000, 5'b01000, 1'b1, 32'h41200000, 32'h3F000000);
    tbl[8] = mk(32'h0000FFFF, 32'hFFFF0001, 3'd0, 1'b0, 1'b1, 4'd12, 32'h1234FFFF, 5'b00010, 5,     32'h0000FFFF, 5'b00010, 1'b0, 32'h0000FFFF, 32'h00000001);
    tbl[9] = mk(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0, 1'b1, 1'b0, 4'd15, 32'h7F800000, 5'b10010, 1,     32'h7F800000, 5'b10010, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_alu_rst", bus.alu_rst, 1'b1);
    check("rst_alu_start", bus.alu_start, 1'b0);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_alu_op_a", bus.alu_op_a, 32'h0);
    check("rst_rsp_result", bus.rsp_result, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready_low", bus.req_ready, 1'b0);
    check("rel_alu_rst_low", bus.alu_rst, 1'b0);
    @(posedge clk);
    #1;
    check("rel_req_ready_high", bus.req_ready, 1'b1);

    // Cycle-exact latency of a single request into an idle, empty issuer
    v = mk(32'h40000000, 32'h40400000, 3'd0, 1'b1, 1'b0, 4'd1, 32'h40A00000, 5'b00000, 0,
           32'h40A00000, 5'b00000, 1'b0, 32'h40000000, 32'h40400000);
    drive_push(v);
    @(negedge clk); check("lat_c0_rst", bus.alu_rst, 1'b0);
    @(negedge clk); check("lat_c1_rst", bus.alu_rst, 1'b1);
                    check("lat_c1_start", bus.alu_start, 1'b0);
    @(negedge clk); check("lat_c2_rst", bus.alu_rst, 1'b0);
                    check("lat_c2_start", bus.alu_start, 1'b0);
    @(negedge clk); check("lat_c3_start", bus.alu_start, 1'b1);
    @(negedge clk); check("lat_c4_start", bus.alu_start, 1'b0);
                    check("lat_c4_rsp", bus.rsp_valid, 1'b0);
    @(negedge clk); check("lat_c5_rsp", bus.rsp_valid, 1'b1);
    @(posedge clk); #1;
    wait_drain();

    // Vector table under random response backpressure
    rand_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_push(tbl[i]);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain();
    rand_en = 1'b0;

    // Timeout: response exactly TIMEOUT_CYCLES edges after entering WAIT
    v = mk(32'h3F800000, 32'h40000000, 3'd1, 1'b1, 1'b0, 4'd13, 32'h0, 5'b00000, NEVER,
           32'h7FC00000, 5'b01000, 1'b1, 32'h3F800000, 32'h40000000);
    drive_push(v);
    wait_start(seen);
    check("tmo_start_seen", seen, 1'b1);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      if (bus.rsp_valid) break;
    end
    check("tmo_latency", k, 9);
    @(posedge clk); #1;
    wait_drain();

    // Backpressure: one in flight plus a full FIFO, then in-order drain
    man_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = mk(32'h40000000 + i, 32'h3F800000, 3'd0, 1'b1, 1'b0, 4'(i), 32'h41000000 + i, 5'(i), 1,
             32'h41000000 + i, 5'(i), 1'b0, 32'h40000000 + i, 32'h3F800000);
      drive_push(v);
    end
    repeat (20) @(negedge clk);
    check("bp_req_ready", bus.req_ready, 1'b0);
    check("bp_busy", bus.busy, 1'b1);
    check("bp_rsp_valid", bus.rsp_valid, 1'b1);
    check("bp_rsp_tag", bus.rsp_tag, 4'd0);
    check("bp_queued", rsp_q.size(), 5);
    @(posedge clk); #1;
    man_rdy = 1'b1;
    wait_drain();

    // Reset during WAIT with a second request queued behind it
    v = mk(32'h40400000, 32'h40400000, 3'd0, 1'b1, 1'b0, 4'd14, 32'h0, 5'b00000, NEVER,
           32'h7FC00000, 5'b01000, 1'b1, 32'h40400000, 32'h40400000);
    drive_push(v);
    v = mk(32'h40800000, 32'h40800000, 3'd0, 1'b1, 1'b0, 4'd2, 32'h41000000, 5'b00000, 0,
           32'h41000000, 5'b00000, 1'b0, 32'h40800000, 32'h40800000);
    drive_push(v);
    wait_start(seen);
    check("rw_start_seen", seen, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_alu_rst", bus.alu_rst, 1'b1);
    check("rw_rsp_valid", bus.rsp_valid, 1'b0);
    check("rw_busy", bus.busy, 1'b0);
    check("rw_req_ready", bus.req_ready, 1'b0);
    rsp_q.delete();
    n_alu_exp -= alu_q.size();
    alu_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    man_v = 1'b1;
    bus.alu_result = 32'h12345678;
    @(posedge clk); #1;
    man_v = 1'b0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.alu_start) nv++;
    end
    check("rw_no_activity", nv, 0);
    check("rw_idle", bus.busy, 1'b0);

    // Every ALU-bound request got exactly one reset pulse and one start pulse
    check("alu_rst_pulses", n_rst_pulse, n_alu_exp);
    check("alu_start_pulses", n_start, n_alu_exp);
    check("alu_q_empty", alu_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
